// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the sequential ripple-carry adder (rca_seq_ctrl).
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  // Slice index width; a single-slice build still needs a 1-bit index.
  function automatic int idx_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// SLICE-bit combinational ripple-carry adder, shared by every slice step of rca_seq_ctrl.
module rca_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic carry_v;

  always_comb begin
    carry_v = cin;
    sum     = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_v;
      carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
    end
    cout = carry_v;
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder reusing one SLICE-bit ripple slice, LSB slice first.
// Optional signed-overflow output ovf is enabled by defining RCA_SEQ_OVERFLOW_EN.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RCA_SEQ_OVERFLOW_EN
  output logic             ovf,
`endif
  output state_t           fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends combinationally on ready, and ready is registered.

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = idx_width(NSLICE);

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("rca_seq_ctrl: WIDTH must be a multiple of SLICE");
  end

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_sum;
  logic             sl_cout;

  assign sl_a      = a_reg[idx*SLICE +: SLICE];
  assign sl_b      = b_reg[idx*SLICE +: SLICE];
  assign fsm_state = state;

  rca_slice #(.SLICE(SLICE)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
`ifdef RCA_SEQ_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[idx*SLICE +: SLICE] <= sl_sum;
          carry                   <= sl_cout;
          if (idx == IW'(NSLICE - 1)) begin
            idx       <= '0;
            cout      <= sl_cout;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef RCA_SEQ_OVERFLOW_EN
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            ovf <= (sl_a[SLICE-1] ^ sl_b[SLICE-1] ^ sl_sum[SLICE-1]) ^ sl_cout;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: driver tasks, expected-result queue, final report.
module tb_rca_seq_ctrl;
  import rca_seq_pkg::*;

  localparam int W      = 16;
  localparam int NSLICE = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
`ifdef RCA_SEQ_OVERFLOW_EN
  logic          ovf;
`endif
  state_t        fsm_state;

  logic [W:0]    exp_q[$];
  int            checks = 0;
  int            errors = 0;

  rca_seq_ctrl #(.WIDTH(W), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef RCA_SEQ_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation; the expected {cout,sum} is queued at drive time.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n;
    n = 0;
    exp_q.push_back({1'b0, x} + {1'b0, y} + {{W{1'b0}}, c});
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom_range(0, 1));
  endtask

  // Wait for the result, optionally stall it with out_ready low, then hand it off.
  task automatic collect(input string tag, input int hold, input bit poke);
    int n;
    logic [W:0] exp_v;
    logic [W:0] held;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(NSLICE));
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_sum"}, 32'(sum), 32'(exp_v[W-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp_v[W]));
`ifdef RCA_SEQ_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(ovf),
          32'((exp_v[W-1] ^ a_hist[W-1] ^ b_hist[W-1]) ^ exp_v[W]));
`endif
    held = {cout, sum};
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk);
      #1;
      check({tag, "_hold_data"}, 32'({cout, sum}), 32'(held));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
    if (poke) begin
      @(posedge clk);
      #1;
      check({tag, "_poke_ignored"}, 32'(fsm_state), 32'(IDLE));
    end
  endtask

`ifdef RCA_SEQ_OVERFLOW_EN
  logic [W-1:0] a_hist;
  logic [W-1:0] b_hist;
`endif

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic c, input int hold, input bit poke);
`ifdef RCA_SEQ_OVERFLOW_EN
    a_hist = x;
    b_hist = y;
`endif
    send(x, y, c);
    collect(tag, hold, poke);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    op("zero",    16'h0000, 16'h0000, 1'b0, 0, 1'b0);
    op("small",   16'h0005, 16'h0003, 1'b0, 0, 1'b0);
    op("ripple",  16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    op("alt",     16'hAAAA, 16'h5555, 1'b1, 0, 1'b0);
    op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    op("stall",   16'h1357, 16'h2468, 1'b1, 5, 1'b1);

    // Abort mid-RUN at idx=2 with some slices already written.
    send(16'hFFFF, 16'hFFFF, 1'b1);
    void'(exp_q.pop_back());
    check("run_state", 32'(fsm_state), 32'(RUN));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    op("after_abort", 16'h1234, 16'h1111, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      op("random", ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
    end

`ifdef RCA_SEQ_OVERFLOW_EN
    op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    op("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
